// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial adder controller.
package serial_add_ctrl_pkg;

  // Controller states; encodings are shared with other blocks that decode them.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Supported operand width range.
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

  // Counter width needed to count 0..w.
  function automatic int cnt_width(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_add_if.sv
// Request/result bundle between a requester and serial_add_ctrl.
interface serial_add_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;

  modport master (
    output start, a, b, ci,
    input  busy, done, s, co
  );

  modport slave (
    input  start, a, b, ci,
    output busy, done, s, co
  );
endinterface

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full adder, reused by the serial adder datapath.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder sequenced over WIDTH cycles, LSB first.
// Operands are captured on an accepted start; the result and a one-cycle
// done pulse appear WIDTH edges later. s/co hold the last completed result.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  serial_add_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             fa_s, fa_co;
  logic [WIDTH-1:0] s_q;
  logic             co_q;
  logic             done_q;

  // The only arithmetic in the block: current bit pair plus stored carry.
  fa U0_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  // Sum shift register entry: new bit enters at the MSB so that after WIDTH
  // shifts bit 0 of the operands lands in bit 0 of the sum.
  generate
    if (WIDTH == 1) begin : g_w1
      assign s_nxt = fa_s;
    end else begin : g_wn
      assign s_nxt = {fa_s, s_sr[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE, so requests while
  // busy are dropped rather than queued.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_RUN;
      ST_RUN:  if (last)      state_nxt = ST_DONE;
      ST_DONE:                state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, per-bit shift, carry and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      s_sr   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      s_q    <= '0;
      co_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= bus.ci;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          s_sr  <= s_nxt;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          if (last) begin
            s_q    <= s_nxt;
            co_q   <= fa_co;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.co   = co_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  serial_add_if #(.WIDTH(8)) bus ();

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation with a one-cycle start pulse; checks busy, hold of the
  // previous result during RUN, the done pulse and the final result.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic [7:0] exp_s, input logic exp_co,
                        input logic [7:0] prev_s, input logic prev_co);
    bus.a = a; bus.b = b; bus.ci = ci; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy_acc"}, 32'(bus.busy), 32'd1);
    for (int i = 0; i < 7; i++) tick();
    chk({tag, "_done_early"}, 32'(bus.done), 32'd0);
    chk({tag, "_s_held"}, 32'(bus.s), 32'(prev_s));
    chk({tag, "_co_held"}, 32'(bus.co), 32'(prev_co));
    tick();
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_s"}, 32'(bus.s), 32'(exp_s));
    chk({tag, "_co"}, 32'(bus.co), 32'(exp_co));
    tick();
    chk({tag, "_done_fall"}, 32'(bus.done), 32'd0);
    chk({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
  endtask

  int first_done, ndone, last_done;

  initial begin
    bus.start = 1'b1; bus.a = 8'hA5; bus.b = 8'h5A; bus.ci = 1'b1;
    reset = 1'b1;

    // 1: reset holds everything at zero even with start asserted
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_s", 32'(bus.s), 32'd0);
      chk("rst_co", 32'(bus.co), 32'd0);
    end
    bus.start = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // 2..3: basic sums, including full carry out
    run_op("t2", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 8'h00, 1'b0);
    run_op("t3a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h10, 1'b0);
    run_op("t3b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1);

    // 4: start while busy is ignored, operand changes after capture ignored
    bus.a = 8'h12; bus.b = 8'h34; bus.ci = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    bus.a = 8'hAA; bus.b = 8'h55; bus.ci = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.a = 8'h33; bus.b = 8'hCC;
    for (int i = 0; i < 3; i++) tick();
    chk("t4_done_early", 32'(bus.done), 32'd0);
    tick();
    chk("t4_done", 32'(bus.done), 32'd1);
    chk("t4_s", 32'(bus.s), 32'h46);
    chk("t4_co", 32'(bus.co), 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) ndone++;
    end
    chk("t4_single_done", 32'(ndone), 32'd0);
    chk("t4_idle", 32'(bus.busy), 32'd0);

    // 5: reset mid-RUN aborts and clears asynchronously
    bus.a = 8'h80; bus.b = 8'h80; bus.ci = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #2 reset = 1'b1;
    #1;
    chk("t5_busy_async", 32'(bus.busy), 32'd0);
    chk("t5_s_async", 32'(bus.s), 32'd0);
    chk("t5_co_async", 32'(bus.co), 32'd0);
    chk("t5_done_async", 32'(bus.done), 32'd0);
    tick();
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done) ndone++;
    end
    chk("t5_no_done", 32'(ndone), 32'd0);
    run_op("t5b", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);

    // 6: start held high; one result every WIDTH+2 cycles
    bus.a = 8'h01; bus.b = 8'h01; bus.ci = 1'b1; bus.start = 1'b1;
    ndone = 0; first_done = -1; last_done = -1;
    for (int c = 1; c <= 35; c++) begin
      tick();
      if (bus.done) begin
        chk("t6_s", 32'(bus.s), 32'h03);
        chk("t6_co", 32'(bus.co), 32'd0);
        if (last_done >= 0) chk("t6_spacing", 32'(c - last_done), 32'd10);
        else first_done = c;
        last_done = c;
        ndone++;
      end
    end
    bus.start = 1'b0;
    chk("t6_first_done", 32'(first_done), 32'd9);
    chk("t6_pulses", 32'(ndone), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
